// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the RV32I fetch stage: NOP encoding, opcode map,
// reset defaults and the {pc,inst} record carried through the fetch queue.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          QDEPTH_DEFAULT   = 2;

  // Major opcodes as seen in inst[6:2]; the fixed 2'b11 suffix is dropped.
  typedef enum logic [4:0] {
    OP_LOAD   = 5'b00000,
    OP_ITYPE  = 5'b00100,
    OP_AUIPC  = 5'b00101,
    OP_STORE  = 5'b01000,
    OP_RTYPE  = 5'b01100,
    OP_LUI    = 5'b01101,
    OP_BRANCH = 5'b11000,
    OP_JALR   = 5'b11001,
    OP_JAL    = 5'b11011
  } opcode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        rdy;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input rdy, input rvalid, input rdata);
  modport slave  (input req, input addr, output rdy, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit_queue.sv
// Small synchronous FIFO of fetched {pc,inst} records with flush; push and
// pop may happen in the same cycle.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  fetch_entry_t               wdata_i,
  output fetch_entry_t               rdata_o,
  output logic                       empty_o,
  output logic [$clog2(QDEPTH):0]    count_o
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(QDEPTH);

  logic [AW:0]  wptr_q, rptr_q;
  fetch_entry_t mem_q [QDEPTH];
  logic         doPush, doPop, full;

  assign count_o = wptr_q - rptr_q;
  assign empty_o = (count_o == '0);
  assign full    = (count_o == DEPTH_W);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full || doPop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (doPush) wptr_q <= wptr_q + 1'b1;
      if (doPop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage with F/D pipeline register: PC generation,
// single-outstanding imem requests, response queue/bypass and decode fields.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = QDEPTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  fetch_unit_if.master        imem,
  input  logic                stall_i,
  input  logic                next_pc_sel_i,
  input  logic [31:0]         jb_pc_i,
  output logic                D_valid_o,
  output logic [31:0]         D_pc_o,
  output logic [31:0]         D_inst_o,
  output logic [4:0]          opcode_o,
  output logic [2:0]          f3_o,
  output logic                f7_o,
  output logic [4:0]          rs1_o,
  output logic [4:0]          rs2_o,
  output logic [4:0]          rd_o
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(QDEPTH);

  logic [31:0]  fetchPc_q, fetchPc_d;
  logic [31:0]  reqPc_q, reqPc_d;
  logic         outstanding_q, outstanding_d;
  logic         discard_q, discard_d;
  logic         dValid_q, dValid_d;
  logic [31:0]  dPc_q, dPc_d;
  logic [31:0]  dInst_q, dInst_d;

  logic         respLive, respUse, advance, bypass, qPush, qPop, qEmpty, accept;
  logic [AW:0]  qCount, occNext;
  fetch_entry_t qHead, respEntry;

  assign respLive  = imem.rvalid && outstanding_q;
  assign respUse   = respLive && !discard_q && !next_pc_sel_i;
  assign advance   = !stall_i && !next_pc_sel_i;
  assign qPop      = advance && !qEmpty;
  assign bypass    = advance && qEmpty && respUse;
  assign qPush     = respUse && !bypass;
  assign occNext   = qCount + (AW + 1)'(qPush) - (AW + 1)'(qPop);
  assign respEntry = '{pc: reqPc_q, inst: imem.rdata};

  // A request is only issued if its response is guaranteed a queue slot.
  assign imem.req  = rst && !next_pc_sel_i && (!outstanding_q || imem.rvalid)
                     && (occNext < DEPTH_W);
  assign imem.addr = fetchPc_q;
  assign accept    = imem.req && imem.rdy;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (qPush),
    .pop_i   (qPop),
    .flush_i (next_pc_sel_i),
    .wdata_i (respEntry),
    .rdata_o (qHead),
    .empty_o (qEmpty),
    .count_o (qCount)
  );

  always_comb begin
    fetchPc_d     = fetchPc_q;
    reqPc_d       = reqPc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    dValid_d      = dValid_q;
    dPc_d         = dPc_q;
    dInst_d       = dInst_q;

    if (next_pc_sel_i)  fetchPc_d = wordAlign(jb_pc_i);
    else if (accept)    fetchPc_d = fetchPc_q + 32'd4;
    if (accept)         reqPc_d   = fetchPc_q;

    if (accept)         outstanding_d = 1'b1;
    else if (respLive)  outstanding_d = 1'b0;

    // An in-flight request that is not answered this cycle becomes stale.
    if (next_pc_sel_i)  discard_d = outstanding_q && !imem.rvalid;
    else if (respLive)  discard_d = 1'b0;

    if (next_pc_sel_i) begin
      dValid_d = 1'b0;
      dInst_d  = NOP_INST;
    end else if (advance) begin
      if (qPop) begin
        dValid_d = 1'b1;
        dPc_d    = qHead.pc;
        dInst_d  = qHead.inst;
      end else if (bypass) begin
        dValid_d = 1'b1;
        dPc_d    = reqPc_q;
        dInst_d  = imem.rdata;
      end else begin
        dValid_d = 1'b0;
        dInst_d  = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetchPc_q     <= RESET_PC;
      reqPc_q       <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      dValid_q      <= 1'b0;
      dPc_q         <= '0;
      dInst_q       <= NOP_INST;
    end else begin
      fetchPc_q     <= fetchPc_d;
      reqPc_q       <= reqPc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      dValid_q      <= dValid_d;
      dPc_q         <= dPc_d;
      dInst_q       <= dInst_d;
    end
  end

  assign D_valid_o = dValid_q;
  assign D_pc_o    = dPc_q;
  assign D_inst_o  = dInst_q;
  assign opcode_o  = dInst_q[6:2];
  assign f3_o      = dInst_q[14:12];
  assign f7_o      = dInst_q[30];
  assign rs1_o     = dInst_q[19:15];
  assign rs2_o     = dInst_q[24:20];
  assign rd_o      = dInst_q[11:7];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table covering boot, stall, redirect,
// flush-over-stall and imem back-pressure, then a mid-stream reset sequence.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct {
    string       name;
    logic        stall;
    logic        sel;
    logic [31:0] jb;
    logic        rdy;
    logic        hold;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
    logic [31:0] expInst;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, nextPcSel = 1'b0;
  logic [31:0] jbPc = '0;
  logic        memRdy = 1'b1, holdResp = 1'b0, injectRvalid = 1'b0;
  logic        memRvalid = 1'b0, pend = 1'b0;
  logic [31:0] memRdata = '0, pendData = '0;
  logic        dValid, f7;
  logic [31:0] dPc, dInst;
  logic [4:0]  opcode, rs1, rs2, rd;
  logic [2:0]  f3;
  int          checks = 0;
  int          failures = 0;
  vec_t        vecs[26];

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  assign bus.rdy    = memRdy;
  assign bus.rvalid = memRvalid | injectRvalid;
  assign bus.rdata  = injectRvalid ? 32'hDEAD_BEEF : memRdata;

  fetch_unit #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (bus),
    .stall_i       (stall),
    .next_pc_sel_i (nextPcSel),
    .jb_pc_i       (jbPc),
    .D_valid_o     (dValid),
    .D_pc_o        (dPc),
    .D_inst_o      (dInst),
    .opcode_o      (opcode),
    .f3_o          (f3),
    .f7_o          (f7),
    .rs1_o         (rs1),
    .rs2_o         (rs2),
    .rd_o          (rd)
  );

  // Memory returns addr+0x100 one cycle after accept, or later while holdResp is set.
  always @(posedge clk) begin
    memRvalid <= 1'b0;
    if (bus.req && bus.rdy) begin
      if (holdResp) begin
        pend     <= 1'b1;
        pendData <= bus.addr + 32'h100;
      end else begin
        memRvalid <= 1'b1;
        memRdata  <= bus.addr + 32'h100;
      end
    end else if (pend && !holdResp) begin
      memRvalid <= 1'b1;
      memRdata  <= pendData;
      pend      <= 1'b0;
    end
  end

  function automatic vec_t mk(string n, logic st, logic sel, logic [31:0] jb, logic rdy,
                              logic hold, logic er, logic [31:0] ea, logic ev,
                              logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.name = n; v.stall = st; v.sel = sel; v.jb = jb; v.rdy = rdy; v.hold = hold;
    v.expReq = er; v.expAddr = ea; v.expValid = ev; v.expPc = ep; v.expInst = ei;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkReq(input string name, input logic er, input logic [31:0] ea);
    checkVal({name, ".req"}, {31'b0, bus.req}, {31'b0, er});
    if (er) checkVal({name, ".addr"}, bus.addr, ea);
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [31:0] ep,
                             input logic [31:0] ei);
    logic [31:0] inst;
    inst = ev ? ei : NOP_INST;
    checkVal({name, ".valid"}, {31'b0, dValid}, {31'b0, ev});
    if (ev) checkVal({name, ".pc"}, dPc, ep);
    checkVal({name, ".inst"}, dInst, inst);
    checkVal({name, ".fields"}, {5'b0, opcode, f3, f7, rs1, rs2, rd},
             {5'b0, inst[6:2], inst[14:12], inst[30], inst[19:15], inst[24:20], inst[11:7]});
  endtask

  task automatic applyStimulus(input vec_t v);
    stall     = v.stall;
    nextPcSel = v.sel;
    jbPc      = v.jb;
    memRdy    = v.rdy;
    holdResp  = v.hold;
    #1;
    checkReq(v.name, v.expReq, v.expAddr);
    @(posedge clk);
    #1;
    checkOutput(v.name, v.expValid, v.expPc, v.expInst);
  endtask

  initial begin
    //              name       st sel jb        rdy hold req addr      val pc        inst
    vecs[0]  = mk("boot0",    0, 0, 32'h0,  1, 0,  1, 32'h00, 0, 32'h00, NOP_INST);
    vecs[1]  = mk("boot1",    0, 0, 32'h0,  1, 0,  1, 32'h04, 1, 32'h00, 32'h100);
    vecs[2]  = mk("boot2",    0, 0, 32'h0,  1, 0,  1, 32'h08, 1, 32'h04, 32'h104);
    vecs[3]  = mk("boot3",    0, 0, 32'h0,  1, 0,  1, 32'h0C, 1, 32'h08, 32'h108);
    vecs[4]  = mk("stall0",   1, 0, 32'h0,  1, 0,  1, 32'h10, 1, 32'h08, 32'h108);
    vecs[5]  = mk("stall1",   1, 0, 32'h0,  1, 0,  0, 32'h00, 1, 32'h08, 32'h108);
    vecs[6]  = mk("stall2",   1, 0, 32'h0,  1, 0,  0, 32'h00, 1, 32'h08, 32'h108);
    vecs[7]  = mk("drain0",   0, 0, 32'h0,  1, 0,  1, 32'h14, 1, 32'h0C, 32'h10C);
    vecs[8]  = mk("drain1",   0, 0, 32'h0,  1, 0,  1, 32'h18, 1, 32'h10, 32'h110);
    vecs[9]  = mk("drain2",   0, 0, 32'h0,  1, 1,  1, 32'h1C, 1, 32'h14, 32'h114);
    vecs[10] = mk("waitResp", 0, 0, 32'h0,  1, 1,  0, 32'h00, 1, 32'h18, 32'h118);
    vecs[11] = mk("redirect", 0, 1, 32'h42, 1, 1,  0, 32'h00, 0, 32'h00, NOP_INST);
    vecs[12] = mk("stale0",   0, 0, 32'h0,  1, 0,  0, 32'h00, 0, 32'h00, NOP_INST);
    vecs[13] = mk("stale1",   0, 0, 32'h0,  1, 0,  1, 32'h40, 0, 32'h00, NOP_INST);
    vecs[14] = mk("target",   0, 0, 32'h0,  1, 0,  1, 32'h44, 1, 32'h40, 32'h140);
    vecs[15] = mk("flushSt",  1, 1, 32'h80, 1, 0,  0, 32'h00, 0, 32'h00, NOP_INST);
    vecs[16] = mk("flush1",   0, 0, 32'h0,  1, 0,  1, 32'h80, 0, 32'h00, NOP_INST);
    vecs[17] = mk("tgt0",     0, 0, 32'h0,  1, 0,  1, 32'h84, 1, 32'h80, 32'h180);
    vecs[18] = mk("tgt1",     0, 0, 32'h0,  1, 0,  1, 32'h88, 1, 32'h84, 32'h184);
    vecs[19] = mk("rdyLo0",   0, 0, 32'h0,  0, 0,  1, 32'h8C, 1, 32'h88, 32'h188);
    vecs[20] = mk("rdyLo1",   0, 0, 32'h0,  0, 0,  1, 32'h8C, 0, 32'h00, NOP_INST);
    vecs[21] = mk("rdyLo2",   0, 0, 32'h0,  0, 0,  1, 32'h8C, 0, 32'h00, NOP_INST);
    vecs[22] = mk("rdyLo3",   0, 0, 32'h0,  0, 0,  1, 32'h8C, 0, 32'h00, NOP_INST);
    vecs[23] = mk("rdyHi",    0, 0, 32'h0,  1, 0,  1, 32'h8C, 0, 32'h00, NOP_INST);
    vecs[24] = mk("resume0",  0, 0, 32'h0,  1, 0,  1, 32'h90, 1, 32'h8C, 32'h18C);
    vecs[25] = mk("resume1",  0, 0, 32'h0,  1, 0,  1, 32'h94, 1, 32'h90, 32'h190);

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    #1;
    checkReq("reset", 1'b0, 32'h0);
    checkVal("reset.pc", dPc, 32'h0);
    checkOutput("reset", 1'b0, 32'h0, NOP_INST);
    rst = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < 26; i++) applyStimulus(vecs[i]);

    // A response for 0x94 is in flight when reset hits; a spurious rvalid follows release.
    $display("[TB] mid-stream reset");
    rst = 1'b0;
    #1;
    checkReq("midRst", 1'b0, 32'h0);
    @(posedge clk);
    #1;
    checkVal("midRst.pc", dPc, 32'h0);
    checkOutput("midRst", 1'b0, 32'h0, NOP_INST);
    rst = 1'b1;
    injectRvalid = 1'b1;
    #1;
    checkReq("restart", 1'b1, 32'h0);
    @(posedge clk);
    #1;
    injectRvalid = 1'b0;
    checkOutput("lateRvalid", 1'b0, 32'h0, NOP_INST);
    @(posedge clk);
    #1;
    checkOutput("restart0", 1'b1, 32'h0, 32'h100);
    @(posedge clk);
    #1;
    checkOutput("restart1", 1'b1, 32'h4, 32'h104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
